// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package dsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of DIGIT-wide slices that make up one WIDTH-bit operand.
    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from per-bit full-adder equations.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_addsub.sv
// WIDTH-bit add/subtract computed DIGIT bits per clock, least-significant digit first.
// Build option: define DSA_SATURATE_EN to clamp signed-overflowed results to the signed limits.
module digit_serial_addsub
    import dsa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);
    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_cfg
        $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT");
    end

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     base;
    logic [DIGIT-1:0]  s_dig;
    logic              co, c_msb;

    // Bit offset of the digit currently in the slice; always < WIDTH.
    assign base = IW'(cnt) * IW'(DIGIT);

    digit_adder #(.DIGIT(DIGIT)) u_slice (
        .a     (a_reg[base +: DIGIT]),
        .b     (b_reg[base +: DIGIT]),
        .ci    (carry),
        .s     (s_dig),
        .co    (co),
        .c_msb (c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1, so Cin is replaced by the forced 1.
                        a_reg <= A;
                        b_reg <= Sub ? ~B : B;
                        carry <= Sub ? 1'b1 : Cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    Sum[base +: DIGIT] <= s_dig;
                    carry <= co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Cout     <= co;
                        Overflow <= c_msb ^ co;
`ifdef DSA_SATURATE_EN
                        if (c_msb ^ co)
                            Sum <= a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                  : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench for digit_serial_addsub; follows DSA_SATURATE_EN when defined.
module tb_digit_serial_addsub;
    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] A, B, Sum;
    logic             Cin, Sub, Cout, Overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
    } op_t;

    digit_serial_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, overflow from operand/result signs.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] be;
        logic             ovf;
        logic             c0;
        be   = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;
        wide = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, c0};
        ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
`ifdef DSA_SATURATE_EN
        if (ovf) wide[WIDTH-1:0] = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return {ovf, wide};
    endfunction

    // Drives one operation through both handshakes; returns the observed result and latency.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub,
                          output logic [WIDTH-1:0] s, output logic co, output logic ov,
                          output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL in_ready_wait: in_ready=%b want 1", in_ready);
        end
        A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        s = Sum; co = Cout; ov = Overflow;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        #12;
        total++;
        if ({in_ready, out_valid, Sum, Cout, Overflow} !== {1'b1, 1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b Sum=%h Cout=%b Ovf=%b want 1 0 0000 0 0",
                     in_ready, out_valid, Sum, Cout, Overflow);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta [7] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000};
        logic [WIDTH-1:0] tb [7] = '{16'h1111, 16'h0001, 16'h0000, 16'h0007, 16'h0005, 16'h0001, 16'h0001};
        logic             tc [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic             ts [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef DSA_SATURATE_EN
        logic [WIDTH-1:0] es [7] = '{16'h2345, 16'h0000, 16'h0100, 16'hFFFE, 16'h0002, 16'h7FFF, 16'h8000};
`else
        logic [WIDTH-1:0] es [7] = '{16'h2345, 16'h0000, 16'h0100, 16'hFFFE, 16'h0002, 16'h8000, 16'h7FFF};
`endif
        logic             ec [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic             eo [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [WIDTH-1:0] s;
        logic             co, ov;
        int               lat;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], tc[i], ts[i], s, co, ov, lat);
            total++;
            if ({s, co, ov} !== {es[i], ec[i], eo[i]}) begin
                bad++;
                $display("FAIL directed_%0d: got Sum=%h Cout=%b Ovf=%b want Sum=%h Cout=%b Ovf=%b",
                         i, s, co, ov, es[i], ec[i], eo[i]);
            end
            total++;
            if (lat !== NDIG) begin
                bad++;
                $display("FAIL directed_latency_%0d: got %0d want %0d", i, lat, NDIG);
            end
            total++;
            if ({in_ready, out_valid} !== 2'b10) begin
                bad++;
                $display("FAIL directed_idle_%0d: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b, s;
        logic             cin, sub, co, ov;
        logic [WIDTH+1:0] exp;
        int               lat;
        for (int i = 0; i < 30; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            exp = model(a, b, cin, sub);
            run_op(a, b, cin, sub, s, co, ov, lat);
            total++;
            if ({ov, co, s} !== exp) begin
                bad++;
                $display("FAIL random_%0d a=%h b=%h cin=%b sub=%b: got Sum=%h Cout=%b Ovf=%b want Sum=%h Cout=%b Ovf=%b",
                         i, a, b, cin, sub, s, co, ov, exp[WIDTH-1:0], exp[WIDTH], exp[WIDTH+1]);
            end
            total++;
            if (lat !== NDIG) begin
                bad++;
                $display("FAIL random_latency_%0d: got %0d want %0d", i, lat, NDIG);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH+1:0] exp;
        int               w;
        exp = model(16'h4321, 16'h0F0F, 1'b1, 1'b0);
        @(negedge clk);
        A = 16'h4321; B = 16'h0F0F; Cin = 1'b1; Sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, in_ready, Overflow, Cout, Sum} !== {1'b1, 1'b0, exp}) begin
                bad++;
                $display("FAIL backpressure_hold_%0d: out_valid=%b in_ready=%b Sum=%h Cout=%b Ovf=%b want 1 0 %h %b %b",
                         i, out_valid, in_ready, Sum, Cout, Overflow, exp[WIDTH-1:0], exp[WIDTH], exp[WIDTH+1]);
            end
            A = WIDTH'($urandom); B = WIDTH'($urandom); Sub = 1'($urandom); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL backpressure_ghost: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] s;
        logic             co, ov;
        int               lat;
        @(negedge clk);
        A = 16'h1234; B = 16'h1111; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, Sum, Cout, Overflow} !== {1'b0, 1'b1, {WIDTH{1'b0}}, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_run: out_valid=%b in_ready=%b Sum=%h Cout=%b Ovf=%b want 0 1 0000 0 0",
                     out_valid, in_ready, Sum, Cout, Overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
        total++;
        if ({s, co, ov, lat} !== {16'h0002, 1'b0, 1'b0, NDIG}) begin
            bad++;
            $display("FAIL reset_fresh_op: got Sum=%h Cout=%b Ovf=%b lat=%0d want 0002 0 0 %0d",
                     s, co, ov, lat, NDIG);
        end
    endtask

    // in_valid and out_ready held high: one result every NDIG+2 cycles, in issue order.
    task automatic test_back_to_back();
        op_t              q[$];
        op_t              op;
        logic [WIDTH+1:0] exp;
        int               last = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_unexpected_out: cycle=%0d Sum=%h want no output", cyc, Sum);
                end else begin
                    op  = q.pop_front();
                    exp = model(op.a, op.b, op.cin, op.sub);
                    if ({Overflow, Cout, Sum} !== exp) begin
                        bad++;
                        $display("FAIL b2b_result: got Sum=%h Cout=%b Ovf=%b want Sum=%h Cout=%b Ovf=%b",
                                 Sum, Cout, Overflow, exp[WIDTH-1:0], exp[WIDTH], exp[WIDTH+1]);
                    end
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== NDIG + 2) begin
                        bad++;
                        $display("FAIL b2b_interval: got %0d want %0d", cyc - last, NDIG + 2);
                    end
                end
                last = cyc;
            end
            if (cyc < 45) begin
                op.a = WIDTH'($urandom); op.b = WIDTH'($urandom);
                op.cin = 1'($urandom); op.sub = 1'($urandom);
                A = op.a; B = op.b; Cin = op.cin; Sub = op.sub; in_valid = 1'b1;
                if (in_ready) q.push_back(op);
            end else begin
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain: %0d results missing want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
